multicycle_controller: RTL

- Multi-cycle successor to the single-cycle MIPS decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables for each state.
- Adds j, a stallable data-memory handshake with a timeout, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath: PC, IR, register file, ALU and data memory.

---
 rtl/multicycle_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle MIPS control FSM. Steps each instruction through IF, ID, EX,
//   MEM and WB and drives the datapath enables for the current state. Adds j,
//   a stallable data-memory handshake with timeout, a sticky illegal-opcode
//   trap and a retired-instruction counter.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   opcode, funct     IR[31:26] / IR[5:0], latched in ID
//   zero              ALU zero flag (beq in EX)
//   mem_ready         data memory completes the access this cycle
//   PCWr, nPC_sel     PC write enable / next-PC source (00 +4, 01 branch, 10 jump)
//   IRWr, RegWr       IR and register-file write enables
//   RegDst, ExtOp     rd/rt select, sign/zero immediate extension
//   ALUSrc, ALUctr    ALU B operand select, ALU operation
//   MemRd, MemWr      data-memory requests
//   MemtoReg          writeback source select
//   trap              sticky fault, cleared only by reset
//   retire            one-cycle pulse when an instruction completes
//   retire_cnt        number of retired instructions (wraps)
//   state             current FSM state, for debug
module multicycle_controller #(
  parameter int ALUCTR_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWr,
  output logic [1:0]          nPC_sel,
  output logic                IRWr,
  output logic                RegWr,
  output logic                RegDst,
  output logic                ExtOp,
  output logic                ALUSrc,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                MemRd,
  output logic                MemWr,
  output logic                MemtoReg,
  output logic                trap,
  output logic                retire,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_J, I_ILL
  } instr_e;

  function automatic instr_e decode(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   decode = (fn == 6'h20) ? I_ADD : (fn == 6'h22) ? I_SUB : I_ILL;
      6'h0d:   decode = I_ORI;
      6'h23:   decode = I_LW;
      6'h2b:   decode = I_SW;
      6'h04:   decode = I_BEQ;
      6'h02:   decode = I_J;
      default: decode = I_ILL;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [5:0]        op_q, fn_q;
  logic [TO_W-1:0]   wait_cnt, wait_d;
  logic [CNT_W-1:0]  cnt_q;
  instr_e            instr_q;

  // Ungated control values; the reset gating is applied at the ports.
  logic       pc_wr, ir_wr, reg_wr, reg_dst, ext_op, alu_src;
  logic       mem_rd, mem_wr, mem_to_reg, trap_c, retire_c;
  logic [1:0] npc;
  logic [2:0] alu_op;

  assign instr_q = decode(op_q, fn_q);

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_cnt;
    pc_wr      = 1'b0;
    npc        = 2'b00;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    ext_op     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    trap_c     = 1'b0;
    retire_c   = 1'b0;

    // ALU controls are decoded in EX and held unchanged through MEM and WB.
    if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      case (instr_q)
        I_ADD, I_LW, I_SW: alu_op = 3'b010;
        I_SUB, I_BEQ:      alu_op = 3'b110;
        I_ORI:             alu_op = 3'b001;
        default:           alu_op = 3'b000;
      endcase
      alu_src = (instr_q == I_ORI) || (instr_q == I_LW) || (instr_q == I_SW);
      ext_op  = (instr_q == I_LW)  || (instr_q == I_SW) || (instr_q == I_BEQ);
    end

    case (state_q)
      S_IF: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        // The register still holds the previous instruction here, so the
        // legality check looks at the live IR fields being latched.
        state_d = (decode(opcode, funct) == I_ILL) ? S_TRAP : S_EX;
      end
      S_EX: begin
        case (instr_q)
          I_ADD, I_SUB, I_ORI: state_d = S_WB;
          I_LW, I_SW:          state_d = S_MEM;
          I_BEQ: begin
            pc_wr    = zero;
            npc      = 2'b01;
            retire_c = 1'b1;
            state_d  = S_IF;
          end
          I_J: begin
            pc_wr    = 1'b1;
            npc      = 2'b10;
            retire_c = 1'b1;
            state_d  = S_IF;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_rd = (instr_q == I_LW);
        mem_wr = (instr_q == I_SW);
        // A completing access wins over a timeout in the same cycle.
        if (mem_ready) begin
          wait_d = '0;
          if (instr_q == I_LW) begin
            state_d = S_WB;
          end else begin
            retire_c = 1'b1;
            state_d  = S_IF;
          end
        end else if (MEM_TIMEOUT != 0 && wait_cnt == TO_W'(MEM_TIMEOUT)) begin
          wait_d  = '0;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = (instr_q == I_ADD) || (instr_q == I_SUB);
        mem_to_reg = (instr_q == I_LW);
        retire_c   = 1'b1;
        state_d    = S_IF;
      end
      S_TRAP: trap_c = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IF;
      op_q     <= '0;
      fn_q     <= '0;
      wait_cnt <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (state_q == S_ID) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // While reset is held, every control output is forced low so the datapath
  // sees no enables before the first clean IF.
  assign PCWr       = rst_n & pc_wr;
  assign nPC_sel    = rst_n ? npc : 2'b00;
  assign IRWr       = rst_n & ir_wr;
  assign RegWr      = rst_n & reg_wr;
  assign RegDst     = rst_n & reg_dst;
  assign ExtOp      = rst_n & ext_op;
  assign ALUSrc     = rst_n & alu_src;
  assign ALUctr     = rst_n ? ALUCTR_W'(alu_op) : '0;
  assign MemRd      = rst_n & mem_rd;
  assign MemWr      = rst_n & mem_wr;
  assign MemtoReg   = rst_n & mem_to_reg;
  assign trap       = rst_n & trap_c;
  assign retire     = rst_n & retire_c;
  assign retire_cnt = cnt_q;
  assign state      = state_q;

endmodule
